// File: rtl/mouse_button_hit_if.sv
// Label-map ROM port: registered read address and range flag out, label data back.
interface mouse_button_hit_if #(
  parameter int ADDR_W  = 17,
  parameter int LABEL_W = 3
);
  logic [ADDR_W-1:0]  map_addr;
  logic               map_in_range;
  logic [LABEL_W-1:0] map_label;

  modport master (output map_addr, output map_in_range, input map_label);
  modport slave  (input map_addr, input map_in_range, output map_label);
endinterface

// File: rtl/mouse_button_hit.sv
// Mouse-over / click detector driven by a downscaled label map in block ROM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no press in progress; waiting for a fresh button rise
// S_ARMED | pressed on a button; click fires if released on the same one
// S_VOID  | pressed on background; ignored until the button is released
module mouse_button_hit #(
  parameter int NUM_BUTTONS = 4,
  parameter int LABEL_W     = 3,
  parameter int MAP_W       = 320,
  parameter int MAP_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [9:0]             mouse_x,
  input  logic [9:0]             mouse_y,
  input  logic                   mouse_left,
  mouse_button_hit_if.master     rom,
  output logic [NUM_BUTTONS-1:0] hover,
  output logic [NUM_BUTTONS-1:0] click,
  output logic                   pressing
);

  localparam logic [31:0] MAP_W_U = MAP_W;
  localparam logic [31:0] MAP_H_U = MAP_H;
  localparam logic [31:0] NUM_U   = NUM_BUTTONS;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_VOID} state_t;

  logic [9:0]             sx, sy;
  logic [31:0]            addr_full;
  logic                   in_range_c;
  logic                   left_s0;
  logic [MEM_LATENCY-1:0] range_dl, left_dl;
  logic                   range_a, lbtn;
  logic                   label_ok;
  logic [LABEL_W-1:0]     label;
  logic [NUM_BUTTONS-1:0] hover_next;

  state_t                 state, state_next;
  logic [LABEL_W-1:0]     armed, armed_next;
  logic                   lbtn_prev;
  logic                   blocked, blocked_next;
  logic                   rise, fall;
  logic [NUM_BUTTONS-1:0] click_next;

  // Full-width address so an out-of-map position cannot alias before the range test.
  assign sx         = mouse_x >> SCALE_SHIFT;
  assign sy         = mouse_y >> SCALE_SHIFT;
  assign addr_full  = 32'(sx) + MAP_W_U * 32'(sy);
  assign in_range_c = (32'(sx) < MAP_W_U) && (32'(sy) < MAP_H_U);

  // Stage 0: register ROM address, range flag and the button level together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom.map_addr     <= '0;
      rom.map_in_range <= 1'b0;
      left_s0          <= 1'b0;
    end else begin
      rom.map_addr     <= addr_full[ADDR_W-1:0];
      rom.map_in_range <= in_range_c;
      left_s0          <= mouse_left;
    end
  end

  // Delay range flag and button level by the ROM latency so they line up with map_label.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_dl <= '0;
      left_dl  <= '0;
    end else begin
      range_dl[0] <= rom.map_in_range;
      left_dl[0]  <= left_s0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        range_dl[i] <= range_dl[i-1];
        left_dl[i]  <= left_dl[i-1];
      end
    end
  end

  assign range_a  = range_dl[MEM_LATENCY-1];
  assign lbtn     = left_dl[MEM_LATENCY-1];
  assign label_ok = range_a && (rom.map_label != '0) && (32'(rom.map_label) <= NUM_U);
  assign label    = label_ok ? rom.map_label : '0;

  // One-hot decode of the aligned label; zero for background.
  always_comb begin
    hover_next = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      if (label == LABEL_W'(k + 1)) hover_next[k] = 1'b1;
    end
  end

  // Hover register, cleared while the screen is inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hover <= '0;
    else     hover <= enable ? hover_next : '0;
  end

  // blocked masks a level that was already high on entry to IDLE until it is released.
  assign rise = lbtn && !lbtn_prev && !blocked;
  assign fall = !lbtn && lbtn_prev;

  // Click FSM next-state and pulse decode.
  always_comb begin
    state_next   = state;
    armed_next   = armed;
    blocked_next = blocked;
    click_next   = '0;
    if (!lbtn) blocked_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          if (label != '0) begin
            state_next = S_ARMED;
            armed_next = label;
          end else begin
            state_next = S_VOID;
          end
        end
      end
      S_ARMED: begin
        if (fall) begin
          state_next = S_IDLE;
          if (label == armed) begin
            for (int k = 0; k < NUM_BUTTONS; k++) begin
              if (armed == LABEL_W'(k + 1)) click_next[k] = 1'b1;
            end
          end
        end
      end
      S_VOID: begin
        if (!lbtn) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (!enable) begin
      state_next   = S_IDLE;
      click_next   = '0;
      blocked_next = 1'b1;
    end
  end

  // Click FSM state, edge history and registered click pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      armed     <= '0;
      lbtn_prev <= 1'b0;
      blocked   <= 1'b1;
      click     <= '0;
    end else begin
      state     <= state_next;
      armed     <= armed_next;
      lbtn_prev <= lbtn;
      blocked   <= blocked_next;
      click     <= click_next;
    end
  end

  assign pressing = (state == S_ARMED);

endmodule
